// File: rtl/otter_cu_fsm.sv
// -----------------------------------------------------------------------------
// otter_cu_fsm
//   Multi-cycle sequencer for the OTTER RISC-V core. It works next to the
//   combinational control decoder. Each instruction goes through fetch and
//   execute. Loads add a writeback wait, and an interrupt entry cycle can
//   follow any instruction. External interrupt requests are latched and are
//   taken only at instruction boundaries.
//
// Parameters
//   LOAD_WAIT  cycles spent in writeback for a load (1..15); this models
//              the data-memory read latency
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous reset, active low
//   opcode     ir[6:0]
//   func3      ir[14:12]
//   intr       external interrupt request (level or single-cycle pulse)
//   mie        machine interrupt enable from the CSR block
//   rst_pc     resets the PC register
//   PCWrite    PC register load enable
//   regWrite   register file write enable
//   memRDEN1   instruction memory read enable
//   memRDEN2   data memory read enable
//   memWE2     data memory write enable
//   csr_WE     CSR write enable
//   int_taken  interrupt entry (decoder selects MTVEC, writes mepc)
//   mret_exec  MRET executing (CSR block restores mie)
// -----------------------------------------------------------------------------
module otter_cu_fsm #(
  parameter int LOAD_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       mie,
  output logic       rst_pc,
  output logic       PCWrite,
  output logic       regWrite,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       memWE2,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] F3_MRET   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;

  // The counter is loaded in EXEC so that it reaches zero on the last
  // writeback cycle.
  localparam logic [3:0] WB_RELOAD = 4'(LOAD_WAIT - 1);

  generate
    if (LOAD_WAIT < 1 || LOAD_WAIT > 15) begin : g_bad_load_wait
      $error("otter_cu_fsm: LOAD_WAIT must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       intr_pend_q, intr_pend_d;
  logic       take;
  logic       is_load;

  // A request is live if it is already latched or is arriving this cycle.
  // It only matters on the final cycle of an instruction.
  assign take    = (intr_pend_q | intr) & mie;
  assign is_load = (opcode == OP_LOAD);

  // ---------------------------------------------------------------------------
  // Next-state, wait counter and pending-interrupt logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    // ST_INTR always leaves to ST_FETCH, so clearing here is the clear on
    // that edge. A request arriving during ST_INTR wins and is kept for
    // the next boundary. Outside ST_INTR the flag is held while mie is 0.
    if (state_q == ST_INTR) begin
      intr_pend_d = intr;
    end else begin
      intr_pend_d = intr_pend_q | intr;
    end

    case (state_q)
      ST_INIT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_load) begin
          wait_cnt_d = WB_RELOAD;
          state_d    = ST_WB;
        end else if (take) begin
          state_d = ST_INTR;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_WB: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else if (take) begin
          state_d = ST_INTR;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_INTR: begin
        state_d = ST_FETCH;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: state plus the current instruction fields
  // ---------------------------------------------------------------------------
  always_comb begin
    rst_pc    = 1'b0;
    PCWrite   = 1'b0;
    regWrite  = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    memWE2    = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    case (state_q)
      ST_INIT: begin
        rst_pc = 1'b1;
      end

      ST_FETCH: begin
        memRDEN1 = 1'b1;
      end

      ST_EXEC: begin
        case (opcode)
          OP_LOAD: begin
            // The PC advances at the end of writeback, not here.
            memRDEN2 = 1'b1;
          end
          OP_STORE: begin
            memWE2  = 1'b1;
            PCWrite = 1'b1;
          end
          OP_BRANCH: begin
            PCWrite = 1'b1;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            PCWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYS: begin
            PCWrite = 1'b1;
            case (func3)
              F3_MRET: begin
                mret_exec = 1'b1;
              end
              F3_CSRRW: begin
                regWrite = 1'b1;
                csr_WE   = 1'b1;
              end
              default: begin
                // Unsupported SYSTEM functions only advance the PC.
              end
            endcase
          end
          default: begin
            // Illegal opcodes only advance the PC.
            PCWrite = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        if (wait_cnt_q != 4'd0) begin
          memRDEN2 = 1'b1;
        end else begin
          regWrite = 1'b1;
          PCWrite  = 1'b1;
        end
      end

      ST_INTR: begin
        int_taken = 1'b1;
        PCWrite   = 1'b1;
      end

      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_INIT;
      wait_cnt_q  <= 4'd0;
      intr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      intr_pend_q <= intr_pend_d;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
`timescale 1ns/1ps
module tb_otter_cu_fsm;

  localparam int LW = 3;

  // Output vector bit order:
  // {rst_pc, PCWrite, regWrite, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec}
  localparam logic [8:0] V_RSTPC = 9'h100;
  localparam logic [8:0] V_PC    = 9'h080;
  localparam logic [8:0] V_RW    = 9'h040;
  localparam logic [8:0] V_RD1   = 9'h020;
  localparam logic [8:0] V_RD2   = 9'h010;
  localparam logic [8:0] V_WE2   = 9'h008;
  localparam logic [8:0] V_CSR   = 9'h004;
  localparam logic [8:0] V_INT   = 9'h002;
  localparam logic [8:0] V_MRET  = 9'h001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       intr;
  logic       mie;
  logic       rst_pc, PCWrite, regWrite, memRDEN1, memRDEN2, memWE2;
  logic       csr_WE, int_taken, mret_exec;
  logic [8:0] got;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign got = {rst_pc, PCWrite, regWrite, memRDEN1, memRDEN2, memWE2,
                csr_WE, int_taken, mret_exec};

  otter_cu_fsm #(.LOAD_WAIT(LW)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .opcode    (opcode),
    .func3     (func3),
    .intr      (intr),
    .mie       (mie),
    .rst_pc    (rst_pc),
    .PCWrite   (PCWrite),
    .regWrite  (regWrite),
    .memRDEN1  (memRDEN1),
    .memRDEN2  (memRDEN2),
    .memWE2    (memWE2),
    .csr_WE    (csr_WE),
    .int_taken (int_taken),
    .mret_exec (mret_exec)
  );

  // Execute-cycle strobes for one instruction, straight from the decode rules.
  function automatic logic [8:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD:   return V_RD2;
      OP_STORE:  return V_PC | V_WE2;
      OP_BRANCH: return V_PC;
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: return V_PC | V_RW;
      OP_SYS: begin
        if (f3 == 3'b000) return V_PC | V_MRET;
        if (f3 == 3'b001) return V_PC | V_RW | V_CSR;
        return V_PC;
      end
      default:   return V_PC;
    endcase
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%b required=%b", name, got, exp);
    end
  endtask

  // Inputs are already driven for this cycle; sample mid-cycle, then advance.
  task automatic cyc(input string name, input logic [8:0] exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[14];
    logic [6:0] ops[12];
    logic [8:0] seq[$];
    logic [6:0] op;
    logic [2:0] f3;
    logic       pend;
    logic       tk;
    int         idx;

    tbl[0]  = '{OP_IMM,    3'b000, V_PC | V_RW};
    tbl[1]  = '{OP_REG,    3'b111, V_PC | V_RW};
    tbl[2]  = '{OP_LUI,    3'b010, V_PC | V_RW};
    tbl[3]  = '{OP_AUIPC,  3'b000, V_PC | V_RW};
    tbl[4]  = '{OP_JAL,    3'b101, V_PC | V_RW};
    tbl[5]  = '{OP_JALR,   3'b000, V_PC | V_RW};
    tbl[6]  = '{OP_STORE,  3'b010, V_PC | V_WE2};
    tbl[7]  = '{OP_BRANCH, 3'b001, V_PC};
    tbl[8]  = '{OP_SYS,    3'b000, V_PC | V_MRET};
    tbl[9]  = '{OP_SYS,    3'b001, V_PC | V_RW | V_CSR};
    tbl[10] = '{OP_SYS,    3'b010, V_PC};
    tbl[11] = '{7'b0000000, 3'b000, V_PC};
    tbl[12] = '{7'b1111111, 3'b011, V_PC};
    tbl[13] = '{OP_LOAD,   3'b010, V_RD2};

    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL,
            OP_JALR, OP_IMM, OP_REG, OP_SYS, OP_SYS, OP_LOAD};

    // Reset held for two edges, then released.
    rst_n  = 1'b0;
    opcode = 7'd0;
    func3  = 3'd0;
    intr   = 1'b0;
    mie    = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_hold", V_RSTPC);
    rst_n = 1'b1;
    cyc("reset_release", V_RSTPC);

    // Decode table, one instruction per record.
    for (int i = 0; i < 14; i++) begin
      opcode = tbl[i].op;
      func3  = tbl[i].f3;
      cyc($sformatf("tbl%0d_fetch", i), V_RD1);
      cyc($sformatf("tbl%0d_exec", i), tbl[i].exp);
      if (tbl[i].op == OP_LOAD) begin
        for (int w = 1; w <= LW; w++) begin
          cyc($sformatf("tbl%0d_wb%0d", i, w), (w == LW) ? (V_PC | V_RW) : V_RD2);
        end
      end
    end

    // Single-cycle request during the fetch of a store.
    mie    = 1'b1;
    opcode = OP_STORE;
    func3  = 3'b010;
    intr   = 1'b1;
    cyc("irq_fetch", V_RD1);
    intr = 1'b0;
    cyc("irq_exec", V_PC | V_WE2);
    cyc("irq_entry", V_PC | V_INT);
    opcode = OP_IMM;
    func3  = 3'b000;
    cyc("irq_next_fetch", V_RD1);
    cyc("irq_next_exec", V_PC | V_RW);

    // Masked request: held through three instructions, taken once mie rises.
    mie  = 1'b0;
    intr = 1'b1;
    cyc("mask_fetch0", V_RD1);
    intr = 1'b0;
    cyc("mask_exec0", V_PC | V_RW);
    for (int i = 1; i < 3; i++) begin
      cyc($sformatf("mask_fetch%0d", i), V_RD1);
      cyc($sformatf("mask_exec%0d", i), V_PC | V_RW);
    end
    mie = 1'b1;
    cyc("mask_fetch3", V_RD1);
    cyc("mask_exec3", V_PC | V_RW);
    cyc("mask_entry", V_PC | V_INT);
    cyc("mask_fetch4", V_RD1);
    cyc("mask_exec4", V_PC | V_RW);

    // Request present during the entry cycle itself re-arms one more entry.
    opcode = OP_REG;
    intr   = 1'b1;
    cyc("rearm_fetch0", V_RD1);
    intr = 1'b0;
    cyc("rearm_exec0", V_PC | V_RW);
    intr = 1'b1;
    cyc("rearm_entry0", V_PC | V_INT);
    intr = 1'b0;
    cyc("rearm_fetch1", V_RD1);
    cyc("rearm_exec1", V_PC | V_RW);
    cyc("rearm_entry1", V_PC | V_INT);
    cyc("rearm_fetch2", V_RD1);
    cyc("rearm_exec2", V_PC | V_RW);

    // Request in the middle of a load wait is deferred to the last wb cycle.
    opcode = OP_LOAD;
    cyc("ldirq_fetch", V_RD1);
    cyc("ldirq_exec", V_RD2);
    intr = 1'b1;
    cyc("ldirq_wb1", V_RD2);
    intr = 1'b0;
    cyc("ldirq_wb2", V_RD2);
    cyc("ldirq_wb3", V_PC | V_RW);
    cyc("ldirq_entry", V_PC | V_INT);
    opcode = OP_BRANCH;
    cyc("ldirq_fetch2", V_RD1);
    cyc("ldirq_exec2", V_PC);

    // MRET finishing with a live request goes straight to interrupt entry.
    opcode = OP_SYS;
    func3  = 3'b000;
    cyc("mret_fetch", V_RD1);
    intr = 1'b1;
    cyc("mret_exec", V_PC | V_MRET);
    intr = 1'b0;
    cyc("mret_entry", V_PC | V_INT);
    func3 = 3'b001;
    cyc("csrrw_fetch", V_RD1);
    cyc("csrrw_exec", V_PC | V_RW | V_CSR);

    // Reset during the first load wait cycle (counter at 2) with a
    // masked request pending: both must be discarded.
    mie    = 1'b0;
    opcode = OP_LOAD;
    func3  = 3'b010;
    intr   = 1'b1;
    cyc("rstld_fetch", V_RD1);
    intr = 1'b0;
    cyc("rstld_exec", V_RD2);
    rst_n = 1'b0;
    cyc("rstld_wb1", V_RD2);
    rst_n = 1'b1;
    cyc("rstld_init", V_RSTPC);
    mie    = 1'b1;
    opcode = OP_IMM;
    func3  = 3'b000;
    cyc("rstld_fetch1", V_RD1);
    cyc("rstld_exec1", V_PC | V_RW);
    opcode = OP_BRANCH;
    cyc("rstld_fetch2", V_RD1);
    cyc("rstld_exec2", V_PC);

    // Random instruction stream against an instruction-level model: each
    // instruction is a list of expected cycles; a request is taken only on
    // the final one, adding one entry cycle.
    pend = 1'b0;
    mie  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      idx = int'($urandom_range(11, 0));
      op  = ops[idx];
      if ($urandom_range(7, 0) == 0) op = 7'($urandom());
      f3 = 3'($urandom());
      opcode = op;
      func3  = f3;

      seq.delete();
      seq.push_back(V_RD1);
      seq.push_back(exec_vec(op, f3));
      if (op == OP_LOAD) begin
        for (int w = 1; w <= LW; w++) seq.push_back((w == LW) ? (V_PC | V_RW) : V_RD2);
      end

      for (int k = 0; k < seq.size(); k++) begin
        intr = ($urandom_range(9, 0) == 0);
        if ($urandom_range(15, 0) == 0) mie = ~mie;
        tk = (k == seq.size() - 1) && ((pend | intr) & mie);
        cyc($sformatf("rnd%0d_c%0d", n, k), seq[k]);
        pend = pend | intr;
        if (tk) begin
          intr = ($urandom_range(9, 0) == 0);
          cyc($sformatf("rnd%0d_entry", n), V_PC | V_INT);
          pend = intr;
        end
      end
    end
    intr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multi-cycle sequencer for the OTTER RISC-V core; works alongside the combinational control decoder.
- Steps each instruction through fetch, execute, optional load writeback and interrupt entry.
- Generates the PC, register-file, memory and CSR write/read strobes.
- Latches external interrupt requests and takes them only at instruction boundaries.

Parameters:
- LOAD_WAIT, 1, number of cycles spent in ST_WB for loads (1..15); models data-memory read latency.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous, active-low reset
- opcode  in  7  ir[6:0]
- func3  in  3  ir[14:12]
- intr  in  1  external interrupt request, level or single-cycle pulse
- mie  in  1  machine interrupt enable from CSR block
- rst_pc  out  1  resets PC register
- PCWrite  out  1  PC register load enable
- regWrite  out  1  register file write enable
- memRDEN1  out  1  instruction memory read enable
- memRDEN2  out  1  data memory read enable
- memWE2  out  1  data memory write enable
- csr_WE  out  1  CSR write enable
- int_taken  out  1  interrupt entry; decoder selects MTVEC and writes mepc
- mret_exec  out  1  MRET executing; CSR block restores mie

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. State, wait counter (4b) and intr_pend are registered. Outputs are combinational from state plus opcode/func3. Every output defaults to 0 in every state.
- Reset: RST=0 at a rising edge forces ST_INIT, clears intr_pend and the counter. This applies from any state, including mid-load and mid-interrupt.
- ST_INIT: rst_pc=1. Next state is ST_FETCH.
- ST_FETCH: memRDEN1=1. Next state is ST_EXEC.
- ST_EXEC, decoded by opcode:
  - LOAD 0000011: memRDEN2=1, PCWrite=0. Counter loads LOAD_WAIT-1. Next state is ST_WB.
  - STORE 0100011: memWE2=1, PCWrite=1.
  - BRANCH 1100011: PCWrite=1.
  - LUI, AUIPC, JAL, JALR, OP_IMM 0010011, OP 0110011: PCWrite=1, regWrite=1.
  - SYS 1110011 with func3=000 (MRET): PCWrite=1, mret_exec=1.
  - SYS with func3=001 (CSRRW): PCWrite=1, regWrite=1, csr_WE=1.
  - Other SYS func3 values and illegal opcodes: PCWrite=1 only; the instruction executes as a NOP.
  - For every non-LOAD opcode, next state is ST_INTR if take=1, else ST_FETCH.
- ST_WB:
  - Counter != 0: decrement, hold ST_WB, all strobes 0 except memRDEN2=1.
  - Counter == 0: regWrite=1, PCWrite=1. Next state is ST_INTR if take=1, else ST_FETCH.
  - LOAD_WAIT=1 gives exactly one ST_WB cycle.
- ST_INTR: int_taken=1, PCWrite=1. intr_pend clears. Next state is ST_FETCH.
- take = (intr_pend | intr) & mie. It is evaluated only in the final cycle of an instruction (ST_EXEC non-load, or ST_WB with counter==0). Interrupts are never taken from ST_INIT, ST_FETCH or mid-wait.
- intr_pend:
  - Set on any cycle with intr=1 while not in ST_INTR.
  - Clears on the edge entering ST_FETCH from ST_INTR.
  - intr=1 during ST_INTR re-sets it, so set dominates clear; this guarantees one entry per fresh request.
  - With mie=0 the pending flag is held, not dropped. It is taken at the first instruction boundary after mie rises.
- An MRET in ST_EXEC with take=1 goes to ST_INTR. mret_exec and int_taken never assert in the same cycle.
- Cycle counts per instruction: 2 cycles for non-load, 2+LOAD_WAIT for load, +1 if an interrupt is taken.

Test Plan:
- Reset sequencing: RST=0 for 2 cycles, then 1. Required: ST_INIT with rst_pc=1, then ST_FETCH with memRDEN1=1 one cycle after release; all other outputs 0 throughout.
- ADDI 0010011: required FETCH→EXEC with PCWrite=1 and regWrite=1 in EXEC, back to FETCH; instruction period 2 cycles.
- LOAD with LOAD_WAIT=3: required memRDEN2=1 in EXEC and the first two WB cycles, regWrite=PCWrite=1 only in the third WB cycle; total 5 cycles.
- Interrupt pulse: 1-cycle intr during FETCH of a STORE, mie=1. Required: memWE2 in EXEC, then ST_INTR with int_taken=1 and PCWrite=1, then FETCH with intr_pend=0.
- Masked interrupt: intr pulse with mie=0, then 3 instructions, then mie=1. Required: no ST_INTR while masked; ST_INTR after the first instruction that completes with mie=1.
- Reset mid-load: RST=0 during ST_WB with counter=2. Required: next state ST_INIT, counter=0, intr_pend=0, no regWrite pulse.
